// File: rtl/at_seq_pkg.sv
// Shared types and constants for the AT command sequencer: FSM state encoding,
// ASCII line terminators and default parameter values.
package at_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_OK,
        NEXT,
        FAIL
    } seq_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned DEF_NUM_CMDS    = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;
    localparam int unsigned DEF_MAX_RETRY   = 3;

    // Longest command is 13 characters, so a 4-bit character index suffices.
    localparam int unsigned CHAR_IDX_W = 4;
    localparam int unsigned CMD_TXT_W  = 8 * 13;

endpackage

// File: rtl/at_cmd_rom.sv
// Combinational AT script ROM: (cmd_idx, char_idx) -> byte to send, plus a flag
// marking the closing LF of each command.
module at_cmd_rom
    import at_seq_pkg::*;
(
    input  logic [2:0]            cmd_idx,
    input  logic [CHAR_IDX_W-1:0] char_idx,
    output logic [7:0]            rom_byte,
    output logic                  last
);

    // Texts are right-aligned: the first character sits in the highest used byte.
    localparam logic [CMD_TXT_W-1:0] CMD0 = CMD_TXT_W'({"AT", ASCII_CR, ASCII_LF});
    localparam logic [CMD_TXT_W-1:0] CMD1 = CMD_TXT_W'({"ATE0", ASCII_CR, ASCII_LF});
    localparam logic [CMD_TXT_W-1:0] CMD2 = CMD_TXT_W'({"AT+CWMODE=1", ASCII_CR, ASCII_LF});
    localparam logic [CMD_TXT_W-1:0] CMD3 = CMD_TXT_W'({"AT+CIPMUX=0", ASCII_CR, ASCII_LF});

    logic [CMD_TXT_W-1:0]  text;
    logic [CHAR_IDX_W-1:0] len;
    int unsigned           pos;

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        text     = '0;
        len      = CHAR_IDX_W'(1);
        pos      = 0;
        rom_byte = 8'h00;
        case (cmd_idx)
            3'd0:    begin text = CMD0; len = CHAR_IDX_W'(4);  end
            3'd1:    begin text = CMD1; len = CHAR_IDX_W'(6);  end
            3'd2:    begin text = CMD2; len = CHAR_IDX_W'(13); end
            3'd3:    begin text = CMD3; len = CHAR_IDX_W'(13); end
            default: begin text = '0;   len = CHAR_IDX_W'(1);  end
        endcase
        if (char_idx < len) begin
            pos      = 8 * (int'(len) - 1 - int'(char_idx));
            rom_byte = text[pos +: 8];
        end
        last = (char_idx == len - CHAR_IDX_W'(1));
    end

endmodule

// File: rtl/at_cmd_sequencer.sv
// AT command script sequencer: sends each ROM command over a UART and waits for OK.
// Define AT_SEQ_RETRY_EN to resend a timed-out command up to MAX_RETRY times.
module at_cmd_sequencer
    import at_seq_pkg::*;
#(
    parameter int unsigned NUM_CMDS    = DEF_NUM_CMDS,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic       iCLK,
    input  logic       RST_n,
    input  logic       start,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       receiver_ok,
    output logic       receive_ok_en,
    output logic [2:0] cmd_idx,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    localparam int unsigned         TIMER_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]          LAST_CMD   = 3'(NUM_CMDS - 1);

    seq_state_e            state, state_d;
    logic [2:0]            cmd_idx_d;
    logic [CHAR_IDX_W-1:0] char_idx, char_idx_d;
    logic [TIMER_W-1:0]    timer, timer_d;
    logic [7:0]            tx_data_d;
    logic                  tx_start_d, done_d, fail_d;
    logic [7:0]            rom_byte;
    logic                  rom_last;

`ifdef AT_SEQ_RETRY_EN
    localparam int unsigned         RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0]             retry, retry_d;
`endif

    at_cmd_rom u_rom (
        .cmd_idx  (cmd_idx),
        .char_idx (char_idx),
        .rom_byte (rom_byte),
        .last     (rom_last)
    );

    assign busy          = (state != IDLE);
    assign receive_ok_en = (state == SEND) || (state == WAIT_TX) || (state == WAIT_OK);

    always_comb begin
        state_d    = state;
        cmd_idx_d  = cmd_idx;
        char_idx_d = char_idx;
        timer_d    = timer;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        fail_d     = fail;
`ifdef AT_SEQ_RETRY_EN
        retry_d    = retry;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    cmd_idx_d  = '0;
                    char_idx_d = '0;
                    timer_d    = '0;
                    fail_d     = 1'b0;
`ifdef AT_SEQ_RETRY_EN
                    retry_d    = '0;
`endif
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rom_byte;
                    state_d    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // tx_start is high only in the first WAIT_TX cycle: that is the
                // guard cycle that gives the UART time to raise tx_busy.
                if (!tx_start && !tx_busy) begin
                    if (rom_last) begin
                        timer_d = '0;
                        state_d = WAIT_OK;
                    end else begin
                        char_idx_d = char_idx + CHAR_IDX_W'(1);
                        state_d    = SEND;
                    end
                end
            end
            WAIT_OK: begin
                // OK arriving in the timeout cycle still wins.
                if (receiver_ok) begin
                    state_d = NEXT;
                end else if (timer == TIMER_LAST) begin
`ifdef AT_SEQ_RETRY_EN
                    if (retry < RETRY_LAST) begin
                        retry_d    = retry + RETRY_W'(1);
                        char_idx_d = '0;
                        state_d    = SEND;
                    end else begin
                        state_d = FAIL;
                    end
`else
                    state_d = FAIL;
`endif
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end
            NEXT: begin
                if (cmd_idx == LAST_CMD) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cmd_idx_d  = cmd_idx + 3'd1;
                    char_idx_d = '0;
`ifdef AT_SEQ_RETRY_EN
                    retry_d    = '0;
`endif
                    state_d    = SEND;
                end
            end
            FAIL: begin
                fail_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            cmd_idx  <= '0;
            char_idx <= '0;
            timer    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
            fail     <= 1'b0;
`ifdef AT_SEQ_RETRY_EN
            retry    <= '0;
`endif
        end else begin
            state    <= state_d;
            cmd_idx  <= cmd_idx_d;
            char_idx <= char_idx_d;
            timer    <= timer_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            done     <= done_d;
            fail     <= fail_d;
`ifdef AT_SEQ_RETRY_EN
            retry    <= retry_d;
`endif
        end
    end

endmodule

// File: doc/at_cmd_sequencer.md
AT_CMD_SEQUENCER -- requirements
Module: at_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_CMDS, default 4, number of AT commands in the script.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50_000_000, iCLK cycles allowed per command for the OK response.
REQ-003 SHALL have parameter MAX_RETRY, default 3, retries per command after timeout.
REQ-004 SHALL have port iCLK  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port RST_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse, begins script.
REQ-007 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-008 SHALL have port tx_start  out  1  one-cycle pulse, transmit tx_data.
REQ-009 SHALL have port tx_data  out  8  byte to transmit.
REQ-010 SHALL have port receiver_ok  in  1  level from the OK detector, held until receive_ok_en falls.
REQ-011 SHALL have port receive_ok_en  out  1  OK-detector enable; low clears detector.
REQ-012 SHALL have port cmd_idx  out  3  index of current command.
REQ-013 SHALL have port busy  out  1  script in progress.
REQ-014 SHALL have port done  out  1  one-cycle pulse, all commands acknowledged.
REQ-015 SHALL have port fail  out  1  sticky failure flag, cleared by next accepted start.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT_TX, WAIT_OK, NEXT, FAIL.
REQ-017 IDLE: start accepted -> cmd_idx=0, char_idx=0, retry=0, fail=0, go SEND; start while busy SHALL be ignored.
REQ-018 SEND: when tx_busy=0, pulse tx_start one cycle with tx_data = ROM byte(cmd_idx,char_idx), go WAIT_TX.
REQ-019 WAIT_TX: wait one guard cycle, then until tx_busy=0; if byte was last of command go WAIT_OK (timer=0) else char_idx+1, go SEND.
REQ-020 receive_ok_en SHALL be 1 only in WAIT_OK and in SEND/WAIT_TX of any command (so OK is never missed); 0 in IDLE, NEXT, FAIL.
REQ-021 WAIT_OK: receiver_ok=1 -> NEXT; else timer increments; timer == TIMEOUT_CYC-1 -> timeout.
REQ-022 receiver_ok=1 in the same cycle as timeout SHALL count as success.
REQ-023 NEXT (one cycle, receive_ok_en=0): if cmd_idx==NUM_CMDS-1 pulse done, go IDLE; else cmd_idx+1, char_idx=0, retry=0, go SEND.
REQ-024 FAIL: set fail=1, go IDLE in next cycle.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Timer width SHALL be $clog2(TIMEOUT_CYC); timer SHALL never wrap.
REQ-027 Each ROM command SHALL end with 0x0D,0x0A; last flag marks 0x0A.

Reset
REQ-028 On RST_n=0: state IDLE, tx_start=0, tx_data=0, receive_ok_en=0, cmd_idx=0, busy=0, done=0, fail=0, timer=0, retry=0.
REQ-029 Reset mid-transfer SHALL abort immediately; no tx_start after release until new start.

Configuration
REQ-030 Macro AT_SEQ_RETRY_EN defined: timeout with retry<MAX_RETRY -> retry+1, char_idx=0, go SEND (resend whole command); retry==MAX_RETRY -> FAIL.
REQ-031 Macro AT_SEQ_RETRY_EN undefined: any timeout -> FAIL; retry counter absent.

Structure
REQ-032 Package at_seq_pkg SHALL hold the state enum, ASCII constants (CR 0x0D, LF 0x0A) and default parameter constants.
REQ-033 Sub-module at_cmd_rom SHALL be combinational: (cmd_idx, char_idx) -> (byte, last); script "AT\r\n", "ATE0\r\n", "AT+CWMODE=1\r\n", "AT+CIPMUX=0\r\n".

Verification
REQ-034 start, tx_busy model 10 cycles/byte, receiver_ok pulse-held after each LF -> 4 commands sent byte-exact, done pulses once, fail=0.
REQ-035 TIMEOUT_CYC=100, no OK for command 1, retry defined -> command 1 sent 4 times, fail=1, done never pulses.
REQ-036 Same, macro undefined -> command 1 sent once, fail=1 after 100 cycles in WAIT_OK.
REQ-037 receiver_ok rises exactly at timer==TIMEOUT_CYC-1 -> treated as success, cmd_idx advances.
REQ-038 RST_n low during command 2 byte 3 -> all outputs reset values next cycle; second start while busy ignored.
